// File: rtl/layer_seq_pkg.sv
// Shared types and defaults for the layer sequencer: FSM state encoding,
// neuron-index width helper and default layer geometry.
package layer_seq_pkg;

    localparam int DEF_NUM_NEURONS = 8;
    localparam int DEF_IN_BITS     = 4;
    localparam int DEF_OUT_BITS    = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // A single-neuron layer still needs a 1-bit index field.
    function automatic int idx_w_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/layer_seq_scheduler_if.sv
// Bus bundle for the layer sequencer: input vector stream, ROM lookup port
// and packed result stream.
interface layer_seq_scheduler_if
    import layer_seq_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int IN_BITS     = DEF_IN_BITS,
    parameter int OUT_BITS    = DEF_OUT_BITS
);
    localparam int IDX_W = idx_w_f(NUM_NEURONS);

    // Both streams are valid/ready: a beat transfers on a rising clock edge
    // where valid && ready; the source holds valid and data until it transfers.
    logic                            in_valid;
    logic                            in_ready;
    logic [NUM_NEURONS*IN_BITS-1:0]  in_data;
    logic                            lut_en;
    logic [IDX_W+IN_BITS-1:0]        lut_addr;
    logic [OUT_BITS-1:0]             lut_data;
    logic                            out_valid;
    logic                            out_ready;
    logic [NUM_NEURONS*OUT_BITS-1:0] out_data;

    modport master (
        output in_valid, in_data, lut_data, out_ready,
        input  in_ready, lut_en, lut_addr, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, lut_data, out_ready,
        output in_ready, lut_en, lut_addr, out_valid, out_data
    );

endinterface

// File: rtl/layer_seq_out_bank.sv
// Result slot register file: one OUT_BITS slot per neuron, written one slot
// per cycle from the ROM return; unwritten slots hold their old contents.
module layer_seq_out_bank
    import layer_seq_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int OUT_BITS    = DEF_OUT_BITS,
    localparam int IDX_W      = idx_w_f(NUM_NEURONS)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [IDX_W-1:0]                wr_idx,
    input  logic [OUT_BITS-1:0]             wr_data,
    output logic [NUM_NEURONS*OUT_BITS-1:0] out_data
);

    logic [NUM_NEURONS*OUT_BITS-1:0] slots_q, slots_d;

    always_comb begin
        slots_d = slots_q;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (wr_en && (wr_idx == IDX_W'(k))) begin
                slots_d[k*OUT_BITS +: OUT_BITS] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
        end
    end

    assign out_data = slots_q;

endmodule

// File: rtl/layer_seq_scheduler.sv
// Sequences one shared neuron truth-table ROM across all neurons of a layer.
// Optional completed-transaction counter enabled by LAYER_SEQ_PERF_CNT_EN.
module layer_seq_scheduler
    import layer_seq_pkg::*;
#(
    parameter int NUM_NEURONS = DEF_NUM_NEURONS,
    parameter int IN_BITS     = DEF_IN_BITS,
    parameter int OUT_BITS    = DEF_OUT_BITS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    layer_seq_scheduler_if.slave        bus,
    output logic [31:0]                 perf_count,
    output state_e                      state_dbg
);

    localparam int IDX_W = idx_w_f(NUM_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

    state_e                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [IDX_W-1:0]               cap_idx_q, cap_idx_d;
    logic                           cap_en_q, cap_en_d;
    logic [NUM_NEURONS*IN_BITS-1:0] vec_q, vec_d;
    logic [IN_BITS-1:0]             slice;
    logic                           wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cap_idx_q <= '0;
            cap_en_q  <= 1'b0;
            vec_q     <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cap_idx_q <= cap_idx_d;
            cap_en_q  <= cap_en_d;
            vec_q     <= vec_d;
        end
    end

    // Select by index compare so unused codes of a non-power-of-2 layer map to nothing.
    always_comb begin
        slice = '0;
        for (int k = 0; k < NUM_NEURONS; k++) begin
            if (idx_q == IDX_W'(k)) begin
                slice = vec_q[k*IN_BITS +: IN_BITS];
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cap_idx_d     = cap_idx_q;
        cap_en_d      = 1'b0;
        vec_d         = vec_q;
        bus.in_ready  = 1'b0;
        bus.lut_en    = 1'b0;
        bus.lut_addr  = '0;
        bus.out_valid = 1'b0;
        unique case (state_q)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    vec_d   = bus.in_data;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                bus.lut_en   = 1'b1;
                bus.lut_addr = {idx_q, slice};
                cap_en_d     = 1'b1;
                cap_idx_d    = idx_q;
                if (idx_q == LAST_IDX) begin
                    idx_d   = '0;
                    state_d = DRAIN;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DRAIN: state_d = DONE;
            DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Abort: nothing is latched and any in-flight ROM return is dropped.
        if (clear) begin
            state_d  = IDLE;
            idx_d    = '0;
            cap_en_d = 1'b0;
            vec_d    = vec_q;
        end
    end

    assign wr_en     = cap_en_q && !clear;
    assign state_dbg = state_q;

    layer_seq_out_bank #(
        .NUM_NEURONS (NUM_NEURONS),
        .OUT_BITS    (OUT_BITS)
    ) u_out_bank (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_idx   (cap_idx_q),
        .wr_data  (bus.lut_data),
        .out_data (bus.out_data)
    );

`ifdef LAYER_SEQ_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (bus.out_valid && bus.out_ready) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_count = perf_q;
`else
    assign perf_count = 32'd0;
`endif

endmodule

// File: tb/tb_layer_seq_scheduler.sv
// Directed bench for layer_seq_scheduler: an 8-neuron and a 1-neuron instance
// driven by hand-computed vectors and a registered ROM model.
module tb_layer_seq_scheduler;
  import layer_seq_pkg::*;

  localparam logic [31:0] VEC1 = 32'h7654_3210;
  localparam logic [31:0] VEC2 = 32'hFEDC_BA98;
  localparam logic [31:0] VEC3 = 32'h0123_4567;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clear8, clear1;
  logic [31:0] perf8, perf1;
  state_e st8, st1;
  int cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  int xfer8 = 0;
  int n0;
  logic ov8_prev = 1'b0;
  logic ov1_prev = 1'b0;

  logic [6:0]  exp_addr8_q[$];
  logic [15:0] exp_data8_q[$];
  logic [4:0]  exp_addr1_q[$];
  logic [1:0]  exp_data1_q[$];
  int acc8_q[$];
  int acc1_q[$];

  layer_seq_scheduler_if #(.NUM_NEURONS(8), .IN_BITS(4), .OUT_BITS(2)) bus8 ();
  layer_seq_scheduler_if #(.NUM_NEURONS(1), .IN_BITS(4), .OUT_BITS(2)) bus1 ();

  layer_seq_scheduler #(.NUM_NEURONS(8), .IN_BITS(4), .OUT_BITS(2)) dut8 (
    .clk(clk), .rst_n(rst_n), .clear(clear8), .bus(bus8),
    .perf_count(perf8), .state_dbg(st8)
  );

  layer_seq_scheduler #(.NUM_NEURONS(1), .IN_BITS(4), .OUT_BITS(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear1), .bus(bus1),
    .perf_count(perf1), .state_dbg(st1)
  );

  // clock / reset / watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ROM model: data for address a appears the cycle after lut_en
  function automatic logic [1:0] rom8(input logic [6:0] a);
    return a[3:2] ^ a[5:4];
  endfunction
  function automatic logic [1:0] rom1(input logic [4:0] a);
    return a[3:2] ^ {1'b0, a[4]};
  endfunction

  always @(posedge clk) begin
    if (bus8.lut_en) bus8.lut_data <= rom8(bus8.lut_addr);
    if (bus1.lut_en) bus1.lut_data <= rom1(bus1.lut_addr);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboards
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus8.lut_en) begin
        if (exp_addr8_q.size() == 0) check("lut8_extra", 1, 0);
        else check("lut8_addr", bus8.lut_addr, exp_addr8_q.pop_front());
      end
      if (bus8.in_valid && bus8.in_ready && !clear8) acc8_q.push_back(cyc);
      if (bus8.out_valid && !ov8_prev && acc8_q.size() > 0) check("lat8", cyc - acc8_q[$], 10);
      if (bus8.out_valid && bus8.out_ready) begin
        xfer8 <= xfer8 + 1;
        if (exp_data8_q.size() == 0) check("out8_extra", 1, 0);
        else check("out8_data", bus8.out_data, exp_data8_q.pop_front());
      end
    end
    ov8_prev <= bus8.out_valid;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus1.lut_en) begin
        if (exp_addr1_q.size() == 0) check("lut1_extra", 1, 0);
        else check("lut1_addr", bus1.lut_addr, exp_addr1_q.pop_front());
      end
      if (bus1.in_valid && bus1.in_ready && !clear1) acc1_q.push_back(cyc);
      if (bus1.out_valid && !ov1_prev && acc1_q.size() > 0) check("lat1", cyc - acc1_q[$], 3);
      if (bus1.out_valid && bus1.out_ready) begin
        if (exp_data1_q.size() == 0) check("out1_extra", 1, 0);
        else check("out1_data", bus1.out_data, exp_data1_q.pop_front());
      end
    end
    ov1_prev <= bus1.out_valid;
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_addr8(input logic [31:0] v, input int cnt);
    logic [2:0] kk;
    for (int k = 0; k < cnt; k++) begin
      kk = 3'(k);
      exp_addr8_q.push_back({kk, v[k*4 +: 4]});
    end
  endtask

  task automatic send8(input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    bus8.in_data = d;
    bus8.in_valid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (bus8.in_ready && !clear8) ok = 1'b1;
      step();
    end
    bus8.in_valid = 1'b0;
    if (!ok) check("send8_timeout", 0, 1);
  endtask

  task automatic send1(input logic [3:0] d);
    bit ok;
    ok = 1'b0;
    bus1.in_data = d;
    bus1.in_valid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (bus1.in_ready && !clear1) ok = 1'b1;
      step();
    end
    bus1.in_valid = 1'b0;
    if (!ok) check("send1_timeout", 0, 1);
  endtask

  task automatic wait_out8(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      if (bus8.out_valid) seen = 1'b1;
      else step();
    end
    if (!seen) check("wait_out8_timeout", 0, 1);
  endtask

  task automatic wait_out1(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      if (bus1.out_valid) seen = 1'b1;
      else step();
    end
    if (!seen) check("wait_out1_timeout", 0, 1);
  endtask

  initial begin
    clear8 = 1'b0; clear1 = 1'b0;
    bus8.in_valid = 1'b0; bus8.in_data = '0; bus8.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.out_ready = 1'b0;
    repeat (3) step();

    // reset state
    check("rst_in_ready", bus8.in_ready, 1);
    check("rst_lut_en", bus8.lut_en, 0);
    check("rst_lut_addr", bus8.lut_addr, 0);
    check("rst_out_valid", bus8.out_valid, 0);
    check("rst_out_data", bus8.out_data, 0);
    check("rst_perf", perf8, 0);
    check("rst_state", st8, IDLE);
    check("rst1_in_ready", bus1.in_ready, 1);
    rst_n = 1'b1;
    step();

    // basic transaction
    bus8.out_ready = 1'b1;
    push_addr8(VEC1, 8);
    exp_data8_q.push_back(16'hB1E4);
    send8(VEC1);
    wait_out8(20);
    check("basic_data", bus8.out_data, 16'hB1E4);
    step();
    check("basic_ready_after", bus8.in_ready, 1);
    check("basic_valid_after", bus8.out_valid, 0);
    check("basic_lut_count", exp_addr8_q.size(), 0);

    // output backpressure
    bus8.out_ready = 1'b0;
    push_addr8(VEC2, 8);
    exp_data8_q.push_back(16'h1B4E);
    send8(VEC2);
    wait_out8(20);
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", bus8.out_valid, 1);
      check("bp_data", bus8.out_data, 16'h1B4E);
      check("bp_in_ready", bus8.in_ready, 0);
      step();
    end
    n0 = xfer8;
    bus8.out_ready = 1'b1;
    step();
    check("bp_one_xfer", xfer8 - n0, 1);
    check("bp_ready_after", bus8.in_ready, 1);
    check("bp_valid_after", bus8.out_valid, 0);

    // back-to-back with in_valid held high
    push_addr8(VEC1, 8);
    exp_data8_q.push_back(16'hB1E4);
    push_addr8(VEC2, 8);
    exp_data8_q.push_back(16'h1B4E);
    bus8.in_data = VEC1;
    bus8.in_valid = 1'b1;
    step();
    bus8.in_data = VEC2;
    for (int i = 0; i < 15 && !bus8.in_ready; i++) step();
    step();
    bus8.in_valid = 1'b0;
    check("b2b_gap", acc8_q[$] - acc8_q[$-1], 11);
    wait_out8(20);
    step();
    check("b2b_drained", exp_data8_q.size(), 0);

    // clear on the 4th lut_en cycle
    push_addr8(VEC3, 4);
    send8(VEC3);
    repeat (3) step();
    clear8 = 1'b1;
    step();
    clear8 = 1'b0;
    check("clr_lut_en", bus8.lut_en, 0);
    check("clr_out_valid", bus8.out_valid, 0);
    check("clr_in_ready", bus8.in_ready, 1);
    clear8 = 1'b1;
    bus8.in_data = VEC3;
    bus8.in_valid = 1'b1;
    step();
    clear8 = 1'b0;
    bus8.in_valid = 1'b0;
    check("clr_no_accept_ready", bus8.in_ready, 1);
    check("clr_no_accept_lut", bus8.lut_en, 0);
    repeat (4) step();
    check("clr_no_valid", bus8.out_valid, 0);
    check("clr_addr_count", exp_addr8_q.size(), 0);
    push_addr8(VEC3, 8);
    exp_data8_q.push_back(16'hE4B1);
    send8(VEC3);
    wait_out8(20);
    check("clr_next_data", bus8.out_data, 16'hE4B1);
    step();

`ifdef LAYER_SEQ_PERF_CNT_EN
    check("perf8_count", perf8, 5);
`else
    check("perf8_count", perf8, 0);
`endif

    // async reset while in DONE
    bus8.out_ready = 1'b0;
    push_addr8(VEC2, 8);
    exp_data8_q.push_back(16'h1B4E);
    send8(VEC2);
    wait_out8(20);
    check("ar_pre_valid", bus8.out_valid, 1);
    exp_data8_q.delete();
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_out_valid", bus8.out_valid, 0);
    check("ar_out_data", bus8.out_data, 0);
    check("ar_perf", perf8, 0);
    check("ar_in_ready", bus8.in_ready, 1);
    check("ar_lut_en", bus8.lut_en, 0);
    step();
    rst_n = 1'b1;
    step();
    check("ar_resume_state", st8, IDLE);

    // single-neuron layer
    bus1.out_ready = 1'b1;
    exp_addr1_q.push_back(5'h0C); exp_data1_q.push_back(2'd3);
    send1(4'hC);
    wait_out1(10);
    check("n1_data_a", bus1.out_data, 2'd3);
    step();
    exp_addr1_q.push_back(5'h05); exp_data1_q.push_back(2'd1);
    send1(4'h5);
    wait_out1(10);
    check("n1_data_b", bus1.out_data, 2'd1);
    step();
    exp_addr1_q.push_back(5'h09); exp_data1_q.push_back(2'd2);
    send1(4'h9);
    wait_out1(10);
    check("n1_data_c", bus1.out_data, 2'd2);
    step();
    check("n1_lut_count", exp_addr1_q.size(), 0);
    check("n1_out_count", exp_data1_q.size(), 0);
`ifdef LAYER_SEQ_PERF_CNT_EN
    check("perf1_count", perf1, 3);
`else
    check("perf1_count", perf1, 0);
`endif

    // final report
    check("final_addr8_empty", exp_addr8_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/layer_seq_scheduler.md
Name: layer_seq_scheduler

Overview:
- Time-multiplexes one shared neuron truth-table ROM across all NUM_NEURONS neurons of a sparse LogicNets layer.
- Accepts one pre-gathered input vector per transaction on a valid/ready handshake.
- Issues one ROM lookup per neuron in index order and packs the OUT_BITS results into one output word.
- Sits between a layer's input gather stage and the next layer. It is the area-reduced alternative to instantiating one combinational ROM per neuron.

Parameters:
- NUM_NEURONS, 8, neurons sequenced per transaction (>=1).
- IN_BITS, 4, fan-in bits per neuron, i.e. ROM address bits per neuron.
- OUT_BITS, 2, output bits per neuron.
- IDX_W, max(1,$clog2(NUM_NEURONS)), neuron index width (derived; do not override).

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clear  in  1  synchronous abort; highest priority after reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  scheduler can accept a vector.
- in_data  in  NUM_NEURONS*IN_BITS  neuron k uses slice [k*IN_BITS +: IN_BITS].
- lut_en  out  1  ROM read strobe.
- lut_addr  out  IDX_W+IN_BITS  {neuron index, input slice}.
- lut_data  in  OUT_BITS  ROM output, valid exactly 1 cycle after lut_en.
- out_valid  out  1  result word valid.
- out_ready  in  1  downstream accepts the result.
- out_data  out  NUM_NEURONS*OUT_BITS  neuron k result at [k*OUT_BITS +: OUT_BITS].
- perf_count  out  32  completed-transaction count (see Optional Feature).

Behaviour:
- Reset values: state IDLE, in_ready=1, lut_en=0, lut_addr=0, out_valid=0, out_data=0, index counter=0, perf_count=0.
- The FSM has four states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register in_data and move to RUN.
- RUN:
  - in_ready=0 and lut_en=1.
  - lut_addr={idx, slice(idx)}.
  - idx increments each cycle from 0 to NUM_NEURONS-1.
  - After issuing NUM_NEURONS-1, move to DRAIN.
- Result capture:
  - One cycle after each lut_en, lut_data is written into out_data slot idx_d, where idx_d is the registered copy of idx.
  - Slots not yet written keep their previous values.
  - out_data is not cleared between transactions.
- DRAIN:
  - lut_en=0.
  - Captures the last result, then moves to DONE.
- DONE:
  - out_valid=1 and out_data is stable.
  - On out_ready, move to IDLE with out_valid=0 on the next cycle.
  - out_ready is ignored in all other states.
- Latency: if the handshake occurs in cycle t, lut_en is high in cycles t+1..t+N and out_valid rises in cycle t+N+2, where N=NUM_NEURONS.
- Throughput: one vector per N+3 cycles with out_ready held high. Input and output do not overlap.
- NUM_NEURONS=1:
  - RUN lasts one cycle with idx=0.
  - IDX_W=1, so the address MSB is 0.
- clear:
  - From any state, go to IDLE next cycle with lut_en=0, out_valid=0 and idx=0.
  - out_data is retained.
  - A pending lookup's return is discarded.
  - clear and in_valid in the same cycle: the input is not accepted.
- Reset mid-transaction:
  - Outputs go to reset values immediately and asynchronously.
  - Operation resumes in IDLE after deassertion.
- idx never wraps past NUM_NEURONS-1; a non-power-of-2 NUM_NEURONS never drives unused indices.

Optional Feature:
- Macro: LAYER_SEQ_PERF_CNT_EN.
- Defined: perf_count increments by 1 on each out_valid&&out_ready. It wraps modulo 2^32 and is reset by rst_n only; clear does not reset it.
- Undefined: no counter logic; perf_count is tied to 0.

Decomposition:
- Shared package layer_seq_pkg holds:
  - the state enum {IDLE, RUN, DRAIN, DONE};
  - the clog2-based IDX_W helper function;
  - the default NUM_NEURONS, IN_BITS and OUT_BITS constants.
- One natural sub-module: layer_seq_out_bank, the slot register file written by {idx_d, capture strobe, lut_data}.
- The FSM and index counter stay in layer_seq_scheduler.

Test Plan:
- Basic transaction:
  - Stimulus: bench ROM returns lut_data=addr[IN_BITS-1:IN_BITS-2]^idx[1:0]; in_data=32'h7654_3210 with out_ready=1.
  - Required: lut_en high for exactly 8 cycles with addresses {0,0x0},{1,0x1},...,{7,0x7}; out_valid in cycle t+10; each slot k equals the ROM value for address {k, k}.
- Output backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles in DONE.
  - Required: out_valid and out_data stable; in_ready=0; exactly one transfer when out_ready rises; in_ready=1 on the next cycle.
- Back-to-back:
  - Stimulus: two vectors, in_valid held high, out_ready=1.
  - Required: second acceptance 11 cycles after the first (N+3); results differ per vector and match the ROM model.
- clear mid-RUN:
  - Stimulus: pulse clear on the 4th lut_en cycle.
  - Required: lut_en=0 next cycle; no out_valid; in_ready=1; the next transaction completes correctly.
- Async reset in DONE:
  - Stimulus: drop rst_n asynchronously while in DONE.
  - Required: out_valid=0 and out_data=0 immediately; perf_count=0.
- NUM_NEURONS=1, with LAYER_SEQ_PERF_CNT_EN defined:
  - Stimulus: 3 transactions.
  - Required: each has exactly one lut_en cycle and out_valid at t+3; perf_count=3.
